// File: rtl/lif_neuron_accum.sv
// Leaky integrate-and-fire neuron: serially accumulates masked synaptic weights, then leaks, thresholds and fires.
// Latency: out_valid N_SYN+1 cycles after transfer (1 cycle when refractory); in_ready only while idle.
// Optional spike counter (cnt_clr / spike_cnt) compiled in when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron_accum #(
  parameter int N_SYN      = 8,
  parameter int V_W        = 16,
  parameter int THRESH     = 100,
  parameter int V_RESET    = 0,
  parameter int LEAK_SHIFT = 3,
  parameter int T_REF      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic               cnt_clr,
  output logic [15:0]        spike_cnt,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_SYN*8-1:0] syn_mask,
  input  logic [N_SYN*8-1:0] syn_weight,
  output logic               out_valid,
  output logic               out_spike,
  output logic [V_W-1:0]     v_mem
);

  localparam int ACC_W = V_W + 4;
  localparam int T_W   = V_W + 5;
  localparam int IDX_W = (N_SYN < 2) ? 1 : $clog2(N_SYN);
  localparam int REF_W = (T_REF < 2) ? 1 : $clog2(T_REF + 1);

  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(N_SYN - 1);
  localparam logic [REF_W-1:0]      REF_INIT  = REF_W'(T_REF);
  localparam logic signed [V_W-1:0] THRESH_V  = V_W'(THRESH);
  localparam logic signed [V_W-1:0] V_RESET_V = V_W'(V_RESET);
  // Signed V_W range expressed at the wider update width, for saturation.
  localparam logic signed [T_W-1:0] T_MAX = {{(T_W-V_W+1){1'b0}}, {(V_W-1){1'b1}}};
  localparam logic signed [T_W-1:0] T_MIN = {{(T_W-V_W+1){1'b1}}, {(V_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [N_SYN*8-1:0]      r_mask;
  logic [N_SYN*8-1:0]      r_weight;
  logic [IDX_W-1:0]        r_idx;
  logic [ACC_W-1:0]        r_acc;
  logic [REF_W-1:0]        r_ref_cnt;
  logic signed [V_W-1:0]   r_v;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_out_spike;

  logic [7:0]              w_prod;
  logic [ACC_W-1:0]        w_acc_next;
  logic signed [T_W-1:0]   w_v_ext;
  logic signed [T_W-1:0]   w_leak;
  logic signed [T_W-1:0]   w_acc_ext;
  logic signed [T_W-1:0]   w_t;
  logic signed [V_W-1:0]   w_t_sat;
  logic                    w_fire;

  // Current synapse contribution: mask AND weight, read as signed 8-bit, added to acc.
  always_comb begin
    w_prod     = r_mask[int'(r_idx)*8 +: 8] & r_weight[int'(r_idx)*8 +: 8];
    w_acc_next = r_acc + {{(ACC_W-8){w_prod[7]}}, w_prod};
  end

  // Leak + integrate at full width, then saturate to V_W and compare against threshold.
  always_comb begin
    w_v_ext   = {{(T_W-V_W){r_v[V_W-1]}}, r_v};
    w_leak    = w_v_ext >>> LEAK_SHIFT;
    w_acc_ext = {{(T_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    w_t       = w_v_ext - w_leak + w_acc_ext;
    if (w_t > T_MAX) begin
      w_t_sat = T_MAX[V_W-1:0];
    end else if (w_t < T_MIN) begin
      w_t_sat = T_MIN[V_W-1:0];
    end else begin
      w_t_sat = w_t[V_W-1:0];
    end
    w_fire = (w_t_sat >= THRESH_V);
  end

  // Timestep FSM: capture on transfer, serial accumulate, then a single update cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_weight    <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_ref_cnt   <= '0;
      r_v         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_spike <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_spike <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mask     <= syn_mask;
            r_weight   <= syn_weight;
            r_idx      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            // A refractory neuron skips integration; its inputs are simply dropped.
            r_state    <= (r_ref_cnt != '0) ? ST_UPDATE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          // ref_cnt is untouched since transfer, so it still tells which path this timestep took.
          if (r_ref_cnt != '0) begin
            r_ref_cnt <= r_ref_cnt - 1'b1;
            r_v       <= V_RESET_V;
          end else if (w_fire) begin
            r_out_spike <= 1'b1;
            r_v         <= V_RESET_V;
            r_ref_cnt   <= REF_INIT;
          end else begin
            r_v <= w_t_sat;
          end
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_spike = r_out_spike;
  assign v_mem     = r_v;

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] r_spike_cnt;

  // Saturating spike counter; a synchronous clear beats a coincident spike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_cnt <= '0;
    end else if (cnt_clr) begin
      r_spike_cnt <= '0;
    end else if (r_out_valid && r_out_spike && (r_spike_cnt != 16'hFFFF)) begin
      r_spike_cnt <= r_spike_cnt + 16'd1;
    end
  end

  assign spike_cnt = r_spike_cnt;
`endif

endmodule

// File: tb/tb_lif_neuron_accum.sv
// Directed bench for lif_neuron_accum with a scoreboard of expected timestep results.
// Each step pushes its expected spike/v_mem/latency, then pops and compares when out_valid appears.
// Spike-counter steps are compiled in only when LIF_SPIKE_COUNT_EN is defined.
module tb_lif_neuron_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] syn_mask;
  logic [63:0] syn_weight;
  logic        out_valid;
  logic        out_spike;
  logic [15:0] v_mem;
`ifdef LIF_SPIKE_COUNT_EN
  logic        cnt_clr;
  logic [15:0] spike_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit clr_at_out = 0;

  typedef struct {
    logic        spike;
    logic [15:0] v;
    int          lat;
  } exp_t;

  exp_t sb[$];

  lif_neuron_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef LIF_SPIKE_COUNT_EN
    .cnt_clr    (cnt_clr),
    .spike_cnt  (spike_cnt),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .syn_mask   (syn_mask),
    .syn_weight (syn_weight),
    .out_valid  (out_valid),
    .out_spike  (out_spike),
    .v_mem      (v_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One timestep: push expectation, transfer, wait bounded for out_valid, pop and compare.
  task automatic step(input string tag, input logic [63:0] m, input logic [63:0] w,
                      input logic es, input logic [15:0] ev, input int elat);
    exp_t e;
    int   lat;
    bit   seen;
    e.spike = es;
    e.v     = ev;
    e.lat   = elat;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    syn_mask   = m;
    syn_weight = w;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    syn_mask   = {$urandom, $urandom};
    syn_weight = {$urandom, $urandom};
    seen = 0;
    lat  = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
      chk({tag, "_spike"}, 32'(out_spike), 32'(e.spike));
      chk({tag, "_vmem"}, 32'(v_mem), 32'(e.v));
      chk({tag, "_rdy_with_valid"}, 32'(in_ready), 32'd1);
`ifdef LIF_SPIKE_COUNT_EN
      if (clr_at_out) cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
`endif
    end
  endtask

  initial begin
    int ov_cnt;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    syn_mask   = '0;
    syn_weight = '0;
`ifdef LIF_SPIKE_COUNT_EN
    cnt_clr    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_spike", 32'(out_spike), 32'd0);
    chk("rst_vmem", 32'(v_mem), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Integrate, fire, two refractory steps, integrate again.
    step("int80",  rep(8'hFF), rep(8'd10), 1'b0, 16'd80, 9);
    step("fire",   rep(8'hFF), rep(8'd10), 1'b1, 16'd0,  9);
    step("ref1",   rep(8'hFF), rep(8'd10), 1'b0, 16'd0,  1);
    step("ref2",   rep(8'hFF), rep(8'd10), 1'b0, 16'd0,  1);
    step("reint",  rep(8'hFF), rep(8'd10), 1'b0, 16'd80, 9);

    // Leak only.
    step("leak70", rep(8'h00), rep(8'd10), 1'b0, 16'd70, 9);
    step("leak62", rep(8'h00), rep(8'd10), 1'b0, 16'd62, 9);
    step("leak55", rep(8'h00), rep(8'd10), 1'b0, 16'd55, 9);

    // Reset in the middle of accumulation: no result must ever appear.
    @(negedge clk);
    in_valid   = 1'b1;
    syn_mask   = rep(8'hFF);
    syn_weight = rep(8'd10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_spike", 32'(out_spike), 32'd0);
    chk("midrst_vmem", 32'(v_mem), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    ov_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_cnt++;
    end
    chk("midrst_no_out_valid", 32'(ov_cnt), 32'd0);

    // Mask semantics: 0x0F & 0xF6 = 0x06 -> +6.
    step("mask", {56'h0, 8'h0F}, {56'h0, 8'hF6}, 1'b0, 16'd6, 9);
    pulse_reset();
    step("neg", rep(8'hFF), rep(8'h80), 1'b0, 16'hFC00, 9);

    // Threshold boundary: 99 stays, 100 fires.
    pulse_reset();
    step("t99", rep(8'hFF), {8'd15, {7{8'd12}}}, 1'b0, 16'd99, 9);
    step("t99leak", rep(8'h00), rep(8'd0), 1'b0, 16'd87, 9);
    pulse_reset();
    step("t100", rep(8'hFF), {8'd16, {7{8'd12}}}, 1'b1, 16'd0, 9);

`ifdef LIF_SPIKE_COUNT_EN
    pulse_reset();
    chk("cnt_rst", 32'(spike_cnt), 32'd0);
    for (int s = 0; s < 3; s++) begin
      step("cnt_fire", rep(8'hFF), rep(8'd13), 1'b1, 16'd0, 9);
      step("cnt_ref1", rep(8'hFF), rep(8'd13), 1'b0, 16'd0, 1);
      step("cnt_ref2", rep(8'hFF), rep(8'd13), 1'b0, 16'd0, 1);
    end
    chk("cnt_three", 32'(spike_cnt), 32'd3);
    clr_at_out = 1;
    step("cnt_clr_fire", rep(8'hFF), rep(8'd13), 1'b1, 16'd0, 9);
    clr_at_out = 0;
    chk("cnt_clr_wins", 32'(spike_cnt), 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
